// File: rtl/insn_encoder_if.sv
// Request/instruction handshake bundle for insn_encoder.
// The master modport is the requester/consumer side; slave is the encoder.
interface insn_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic        insn_last;
  logic        err;

  modport master (
    output req_valid, req_op, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm,
    output insn_ready,
    input  req_ready, insn_valid, insn, insn_last, err
  );

  modport slave (
    input  req_valid, req_op, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm,
    input  insn_ready,
    output req_ready, insn_valid, insn, insn_last, err
  );
endinterface

// File: rtl/insn_encoder.sv
// RV32I instruction encoder: one request in, one (or two, for LI) words out.
// Define INSN_ENC_LI_EN to enable the LI pseudo-op (LUI+ADDI expansion).
module insn_encoder (
  input  logic          clk,
  input  logic          reset,
  insn_encoder_if.slave bus
);

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  logic [31:0] insn_q, insn_d;
  logic        insn_valid_q, insn_valid_d;
  logic        err_q, err_d;
  logic        accept_s;
  logic        is_idle_s;
  logic [31:0] enc_word_s;
  logic        enc_bad_s;
  logic [31:0] imm_s;

`ifdef INSN_ENC_LI_EN
  typedef enum logic [0:0] {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic        insn_last_q, insn_last_d;
  logic        enc_two_s;
  logic [31:0] enc_second_s;
  logic        li_fits_s;
  logic [19:0] li_hi_s;

  // Rounding by +0x800 only carries out of the low 12 bits when imm[11] is set.
  assign li_fits_s = (imm_s[31:11] == {21{imm_s[11]}});
  assign li_hi_s   = imm_s[31:12] + {19'd0, imm_s[11]};
  assign is_idle_s = (state_q == IDLE);
`else
  assign is_idle_s = 1'b1;
`endif

  assign imm_s         = bus.req_imm;
  assign bus.req_ready = is_idle_s && (!insn_valid_q || bus.insn_ready);
  assign accept_s      = bus.req_valid && bus.req_ready;
  assign bus.insn_valid = insn_valid_q;
  assign bus.insn       = insn_q;
  assign bus.err        = err_q;
`ifdef INSN_ENC_LI_EN
  assign bus.insn_last  = insn_last_q;
`else
  assign bus.insn_last  = 1'b1;
`endif

  // Encode the presented request into its first word and flag rejections.
  always_comb begin
    enc_word_s = 32'd0;
    enc_bad_s  = 1'b0;
`ifdef INSN_ENC_LI_EN
    enc_two_s    = 1'b0;
    enc_second_s = 32'd0;
`endif
    case (bus.req_op)
      4'd0: enc_word_s = {imm_s[31:12], bus.req_rd, OPC_LUI};
      4'd1: enc_word_s = {imm_s[31:12], bus.req_rd, OPC_AUIPC};
      4'd2: begin
        enc_bad_s  = imm_s[0];
        enc_word_s = {imm_s[20], imm_s[10:1], imm_s[11], imm_s[19:12], bus.req_rd, OPC_JAL};
      end
      4'd3: enc_word_s = {imm_s[11:0], bus.req_rs1, 3'b000, bus.req_rd, OPC_JALR};
      4'd4: begin
        enc_bad_s  = imm_s[0];
        enc_word_s = {imm_s[12], imm_s[10:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                      imm_s[4:1], imm_s[11], OPC_BRANCH};
      end
      4'd5: enc_word_s = {imm_s[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OPC_LOAD};
      4'd6: enc_word_s = {imm_s[11:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                          imm_s[4:0], OPC_STORE};
      4'd7: begin
        // Shifts carry funct7 in the upper bits and a 5-bit shamt.
        if (bus.req_funct3 == 3'b001 || bus.req_funct3 == 3'b101) begin
          enc_word_s = {bus.req_funct7, imm_s[4:0], bus.req_rs1, bus.req_funct3,
                        bus.req_rd, OPC_OPIMM};
        end else begin
          enc_word_s = {imm_s[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OPC_OPIMM};
        end
      end
      4'd8: enc_word_s = {bus.req_funct7, bus.req_rs2, bus.req_rs1, bus.req_funct3,
                          bus.req_rd, OPC_OP};
`ifdef INSN_ENC_LI_EN
      4'd9: begin
        if (li_fits_s) begin
          enc_word_s = {imm_s[11:0], 5'd0, 3'b000, bus.req_rd, OPC_OPIMM};
        end else if (imm_s[11:0] == 12'd0) begin
          enc_word_s = {li_hi_s, bus.req_rd, OPC_LUI};
        end else begin
          enc_word_s   = {li_hi_s, bus.req_rd, OPC_LUI};
          enc_two_s    = 1'b1;
          enc_second_s = {imm_s[11:0], bus.req_rd, 3'b000, bus.req_rd, OPC_OPIMM};
        end
      end
`endif
      default: enc_bad_s = 1'b1;
    endcase
  end

  // Output register, pending-word queue and FSM next state.
  always_comb begin
    insn_d       = insn_q;
    insn_valid_d = insn_valid_q;
    err_d        = 1'b0;
`ifdef INSN_ENC_LI_EN
    insn_last_d  = insn_last_q;
    state_d      = state_q;
    pend_d       = pend_q;
`endif
    if (accept_s) begin
      if (enc_bad_s) begin
        err_d        = 1'b1;
        insn_valid_d = 1'b0;
      end else begin
        insn_d       = enc_word_s;
        insn_valid_d = 1'b1;
`ifdef INSN_ENC_LI_EN
        if (enc_two_s) begin
          insn_last_d = 1'b0;
          pend_d      = enc_second_s;
          state_d     = PEND;
        end else begin
          insn_last_d = 1'b1;
        end
`endif
      end
`ifdef INSN_ENC_LI_EN
    end else if (state_q == PEND && bus.insn_ready) begin
      insn_d      = pend_q;
      insn_last_d = 1'b1;
      pend_d      = 32'd0;
      state_d     = IDLE;
`endif
    end else if (insn_valid_q && bus.insn_ready) begin
      insn_valid_d = 1'b0;
    end else begin
      insn_valid_d = insn_valid_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      insn_q       <= 32'd0;
      insn_valid_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef INSN_ENC_LI_EN
      insn_last_q  <= 1'b0;
      state_q      <= IDLE;
      pend_q       <= 32'd0;
`endif
    end else begin
      insn_q       <= insn_d;
      insn_valid_q <= insn_valid_d;
      err_q        <= err_d;
`ifdef INSN_ENC_LI_EN
      insn_last_q  <= insn_last_d;
      state_q      <= state_d;
      pend_q       <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_insn_encoder.sv
// Directed self-checking bench for insn_encoder; LI scenarios run only when
// INSN_ENC_LI_EN is defined, otherwise op 9 is checked as illegal.
module tb_insn_encoder;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  insn_encoder_if bus_if ();

  insn_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

`ifdef INSN_ENC_LI_EN
  localparam logic [31:0] EXP_LAST_RST = 32'd0;
`else
  localparam logic [31:0] EXP_LAST_RST = 32'd1;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle; it must be accepted on that edge.
  task automatic send(input logic [3:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    bus_if.req_op     = op;
    bus_if.req_funct3 = f3;
    bus_if.req_funct7 = f7;
    bus_if.req_rd     = rd;
    bus_if.req_rs1    = rs1;
    bus_if.req_rs2    = rs2;
    bus_if.req_imm    = imm;
    bus_if.req_valid  = 1'b1;
    check("req_ready_at_send", bus_if.req_ready, 32'd1);
    step();
    bus_if.req_valid  = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] word, input logic last);
    check({tag, "_valid"}, bus_if.insn_valid, 32'd1);
    check({tag, "_insn"}, bus_if.insn, word);
    check({tag, "_last"}, bus_if.insn_last, {31'd0, last});
    check({tag, "_err"}, bus_if.err, 32'd0);
  endtask

  task automatic expect_reject(input string tag);
    check({tag, "_err"}, bus_if.err, 32'd1);
    check({tag, "_valid"}, bus_if.insn_valid, 32'd0);
    step();
    check({tag, "_err_clr"}, bus_if.err, 32'd0);
    check({tag, "_valid_after"}, bus_if.insn_valid, 32'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus_if.req_valid  = 1'b0;
    bus_if.req_op     = 4'd0;
    bus_if.req_funct3 = 3'd0;
    bus_if.req_funct7 = 7'd0;
    bus_if.req_rd     = 5'd0;
    bus_if.req_rs1    = 5'd0;
    bus_if.req_rs2    = 5'd0;
    bus_if.req_imm    = 32'd0;
    bus_if.insn_ready = 1'b1;
    step();
    step();
    check("rst_valid", bus_if.insn_valid, 32'd0);
    check("rst_insn", bus_if.insn, 32'd0);
    check("rst_last", bus_if.insn_last, EXP_LAST_RST);
    check("rst_err", bus_if.err, 32'd0);
    reset = 1'b1;
    check("ready_after_rst", bus_if.req_ready, 32'd1);

    // Single-word encodings, back to back with insn_ready held high.
    send(4'd7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    expect_word("addi", 32'h0050_0093, 1'b1);
    send(4'd6, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd12);
    expect_word("sw", 32'h0020_A623, 1'b1);
    send(4'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    expect_word("beq", 32'h0020_8463, 1'b1);
    send(4'd4, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
    expect_word("bne_neg", 32'hFE20_9CE3, 1'b1);
    send(4'd0, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'hABCD_E123);
    expect_word("lui", 32'hABCD_E1B7, 1'b1);
    send(4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1000);
    expect_word("auipc", 32'h0000_1097, 1'b1);
    send(4'd2, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    expect_word("jal", 32'h0010_00EF, 1'b1);
    send(4'd3, 3'd5, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC);
    expect_word("jalr_f3", 32'hFFC1_00E7, 1'b1);
    send(4'd5, 3'd2, 7'd0, 5'd5, 5'd1, 5'd0, 32'h0000_07FF);
    expect_word("lw", 32'h7FF0_A283, 1'b1);
    send(4'd7, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3);
    expect_word("srai", 32'h4031_5093, 1'b1);
    send(4'd8, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("sub", 32'h4020_81B3, 1'b1);
    step();
    check("drain_valid", bus_if.insn_valid, 32'd0);

    // Rejected requests.
    send(4'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7);
    expect_reject("bad_branch");
    send(4'd2, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
    expect_reject("bad_jal");
    send(4'd12, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    expect_reject("bad_op12");

`ifdef INSN_ENC_LI_EN
    send(4'd9, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd5);
    expect_word("li_small", 32'h0050_0293, 1'b1);
    send(4'd9, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    expect_word("li_neg1", 32'hFFF0_0093, 1'b1);
    send(4'd9, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5000);
    expect_word("li_lui_only", 32'h1234_50B7, 1'b1);
    check("li_lui_only_ready", bus_if.req_ready, 32'd1);
    send(4'd9, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    expect_word("li2_lui", 32'h1234_62B7, 1'b0);
    check("li2_ready_between", bus_if.req_ready, 32'd0);
    step();
    expect_word("li2_addi", 32'hFFF2_8293, 1'b1);
    send(4'd9, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h0000_0800);
    expect_word("li_2048_lui", 32'h0000_1137, 1'b0);
    step();
    expect_word("li_2048_addi", 32'h8001_0113, 1'b1);
    step();
    check("li_drain", bus_if.insn_valid, 32'd0);

    // Stall the first LI word for three cycles.
    bus_if.insn_ready = 1'b0;
    send(4'd9, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    for (int i = 0; i < 3; i++) begin
      expect_word("stall_lui", 32'h1234_62B7, 1'b0);
      check("stall_ready", bus_if.req_ready, 32'd0);
      step();
    end
    expect_word("stall_lui_end", 32'h1234_62B7, 1'b0);
    bus_if.insn_ready = 1'b1;
    step();
    expect_word("stall_addi", 32'hFFF2_8293, 1'b1);
    step();
    check("stall_drain", bus_if.insn_valid, 32'd0);

    // Reset while the ADDI is pending.
    bus_if.insn_ready = 1'b0;
    send(4'd9, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    check("pend_ready", bus_if.req_ready, 32'd0);
    reset = 1'b0;
    #1;
    check("pend_rst_valid", bus_if.insn_valid, 32'd0);
    check("pend_rst_last", bus_if.insn_last, 32'd0);
    bus_if.insn_ready = 1'b1;
    step();
    reset = 1'b1;
    check("pend_rel_ready", bus_if.req_ready, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("pend_rel_quiet", bus_if.insn_valid, 32'd0);
    end
`else
    send(4'd9, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    expect_reject("li_disabled");

    // Reset while a word is stalled at the output.
    bus_if.insn_ready = 1'b0;
    send(4'd7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    expect_word("hold_word", 32'h0050_0093, 1'b1);
    reset = 1'b0;
    #1;
    check("hold_rst_valid", bus_if.insn_valid, 32'd0);
    bus_if.insn_ready = 1'b1;
    step();
    reset = 1'b1;
    check("hold_rel_ready", bus_if.req_ready, 32'd1);
    step();
    check("hold_rel_quiet", bus_if.insn_valid, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/insn_encoder.md
INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when high with req_valid.
- req_op  input  4  op class: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP-IMM, 8 OP, 9 LI pseudo-op; 10-15 illegal.
- req_funct3  input  3  funct3 field.
- req_funct7  input  7  funct7 field; OP, and OP-IMM shifts only.
- req_rd / req_rs1 / req_rs2  input  5 each  register indices.
- req_imm  input  32  immediate as a full signed byte value.
- insn_valid  output  1  insn holds a word.
- insn_ready  input  1  consumer takes the word.
- insn  output  32  RV32I instruction word.
- insn_last  output  1  insn is the final word of its request.
- err  output  1  one-cycle pulse for a rejected request.

Function
REQ-002 The block SHALL drive req_ready = (state==IDLE) && (!insn_valid || insn_ready).
REQ-003 On accept, the block SHALL register the encoded word; insn_valid SHALL be 1 on the next cycle (latency 1).
REQ-004 Opcodes SHALL be: LUI 0x37, AUIPC 0x17, JAL 0x6F, JALR 0x67, BRANCH 0x63, LOAD 0x03, STORE 0x23, OP-IMM/LI 0x13, OP 0x33.
REQ-005 Formats SHALL be:
- I: imm[11:0],rs1,f3,rd.
- S: imm[11:5],rs2,rs1,f3,imm[4:0].
- B: imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11].
- U: imm[31:12],rd.
- J: imm[20],imm[10:1],imm[11],imm[19:12],rd.
- JALR SHALL force f3 to 0.
REQ-006 For OP-IMM with f3=001/101, bits [31:25] SHALL be req_funct7 and [24:20] SHALL be imm[4:0]; R-type (OP) SHALL use req_funct7,rs2,rs1,f3,rd.
REQ-007 BRANCH or JAL with imm[0]=1, or an illegal req_op, SHALL be consumed with no word emitted and err=1 for exactly the cycle after accept.
REQ-008 While insn_valid && !insn_ready, insn and insn_last SHALL hold stable.
REQ-009 The FSM SHALL have states IDLE and PEND; PEND holds a queued second word.
- IDLE->PEND on accepting a two-word LI.
- PEND->IDLE when the second word is loaded into the output register, which happens on the cycle the first word is consumed.
REQ-010 LI expansion SHALL be:
- If req_imm fits signed 12-bit: one ADDI rd,x0,imm[11:0].
- Else: hi=(imm+0x800)>>12, truncated to 20 bits with wrap allowed. Emit LUI rd,hi, then ADDI rd,rd,imm[11:0].
- If imm[11:0]==0: LUI only.
REQ-011 insn_last SHALL be 0 on the LUI of a two-word LI and 1 on every other word.
REQ-012 Back-to-back single-word requests SHALL sustain one word per cycle while insn_ready=1.

Reset
REQ-013 While reset=0, the block SHALL hold: state=IDLE, insn_valid=0, insn=0, insn_last=0, err=0, pending word cleared.
REQ-014 Reset asserted mid-expansion SHALL drop the pending ADDI; after release the block SHALL emit nothing until a new request.
REQ-015 req_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-016 Macro INSN_ENC_LI_EN SHALL control LI support.
- Defined: LI SHALL be expanded per REQ-009..REQ-011.
- Undefined: the PEND state and second-word register SHALL be absent, req_op=9 SHALL be illegal per REQ-007, and insn_last SHALL be tied to 1.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- op7,f3=0,rd=1,rs1=0,imm=5 -> insn=0x00500093, insn_last=1, one cycle after accept.
- op6,f3=2,rs1=1,rs2=2,imm=12 -> 0x0020A623; then op4,f3=0,rs1=1,rs2=2,imm=8 -> 0x00208463.
- LI rd=5,imm=0x12345FFF with INSN_ENC_LI_EN -> 0x123462B7 (last=0), then 0xFFF28293 (last=1); req_ready=0 between the two words.
- insn_ready=0 for 3 cycles on the first LI word -> insn stable, req_ready=0, second word follows one cycle after release.
- op4,imm=7 -> err=1 for one cycle, insn_valid stays 0; op=12 -> same; op=9 without INSN_ENC_LI_EN -> same.
- reset=0 asserted while state=PEND -> insn_valid=0 immediately; after release no ADDI emitted, req_ready=1.
